// File: rtl/anunciador_alarme.sv
// ============================================================================
// Module   : anunciador_alarme
// Brief    : Operator-side alarm annunciator. Runs a per-channel alarm
//            sequence (new / acknowledged / return-to-normal), drives the
//            horn, blinking panel lamps, first-out indicator and silence
//            timer from the acknowledge, silence and rearm buttons.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module anunciador_alarme #(
  parameter int N_FONTES       = 4,
  parameter int PERIODO_PISCA  = 8,
  parameter int TEMPO_SILENCIO = 64
) (
  input  logic                CLOCK,
  input  logic                reset,
  input  logic [N_FONTES-1:0] alarmeEntrada,
  input  logic                botaoReconhecer,
  input  logic                botaoSilenciar,
  input  logic                botaoRearmar,
  output logic                alarmeSonoro,
  output logic [N_FONTES-1:0] lampadas,
  output logic [N_FONTES-1:0] primeiraFalha,
  output logic                silenciado
);

  localparam int c_W_CNT = (PERIODO_PISCA > 2) ? $clog2(PERIODO_PISCA) : 1;
  localparam int c_W_TIM = $clog2(TEMPO_SILENCIO + 1);

  localparam logic [c_W_CNT-1:0] c_CNT_MAX = c_W_CNT'(PERIODO_PISCA - 1);
  localparam logic [c_W_CNT-1:0] c_CNT_UM  = c_W_CNT'(1);
  localparam logic [c_W_TIM-1:0] c_TEMPO   = c_W_TIM'(TEMPO_SILENCIO);
  localparam logic [c_W_TIM-1:0] c_TIM_UM  = c_W_TIM'(1);

  typedef enum logic [1:0] {
    NORMAL      = 2'b00,
    ALARME      = 2'b01,
    RECONHECIDO = 2'b10,
    RETORNO     = 2'b11
  } estado_t;

  // Channel state and its next value
  estado_t r_estado [N_FONTES];
  estado_t w_prox   [N_FONTES];

  // Button history; r_armado blocks an edge on the first cycle after reset
  // so a button held through reset release is not taken as a press.
  logic r_rec_d;
  logic r_sil_d;
  logic r_rea_d;
  logic r_armado;

  logic w_ack;
  logic w_sil;
  logic w_rea;

  logic [c_W_CNT-1:0]  r_cont;
  logic                r_fase;
  logic [c_W_TIM-1:0]  r_timer;
  logic                r_sonoro;
  logic [N_FONTES-1:0] r_lamp;
  logic [N_FONTES-1:0] r_pf;

  logic [N_FONTES-1:0] w_entra;
  logic [N_FONTES-1:0] w_pf_novo;
  logic                w_achou;
  logic                w_req;
  logic                w_todos_normal;

  assign w_ack = botaoReconhecer & ~r_rec_d & r_armado;
  assign w_sil = botaoSilenciar  & ~r_sil_d & r_armado;
  assign w_rea = botaoRearmar    & ~r_rea_d & r_armado;

  // Button delay line for rising-edge detection
  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      r_rec_d  <= 1'b0;
      r_sil_d  <= 1'b0;
      r_rea_d  <= 1'b0;
      r_armado <= 1'b0;
    end else begin
      r_rec_d  <= botaoReconhecer;
      r_sil_d  <= botaoSilenciar;
      r_rea_d  <= botaoRearmar;
      r_armado <= 1'b1;
    end
  end

  // Next channel states, alarm entries, horn request and first-out candidate
  always_comb begin
    w_entra        = '0;
    w_req          = 1'b0;
    w_todos_normal = 1'b1;
    w_pf_novo      = '0;
    w_achou        = 1'b0;
    for (int k = 0; k < N_FONTES; k++) begin
      w_prox[k] = r_estado[k];
      case (r_estado[k])
        NORMAL: begin
          if (alarmeEntrada[k]) w_prox[k] = ALARME;
        end
        ALARME: begin
          if (w_ack)                  w_prox[k] = alarmeEntrada[k] ? RECONHECIDO : NORMAL;
          else if (!alarmeEntrada[k]) w_prox[k] = RETORNO;
        end
        RECONHECIDO: begin
          if (!alarmeEntrada[k]) w_prox[k] = NORMAL;
        end
        RETORNO: begin
          if (alarmeEntrada[k]) w_prox[k] = ALARME;
          else if (w_ack)       w_prox[k] = NORMAL;
        end
        default: w_prox[k] = NORMAL;
      endcase
      w_entra[k] = (w_prox[k] == ALARME) && (r_estado[k] != ALARME);
      if ((r_estado[k] == ALARME) || (r_estado[k] == RETORNO)) w_req = 1'b1;
      if (r_estado[k] != NORMAL) w_todos_normal = 1'b0;
      // Lowest-index entry wins the first-out slot
      if (w_entra[k] && !w_achou) begin
        w_pf_novo[k] = 1'b1;
        w_achou      = 1'b1;
      end
    end
  end

  // Channel state registers
  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N_FONTES; k++) r_estado[k] <= NORMAL;
    end else begin
      for (int k = 0; k < N_FONTES; k++) r_estado[k] <= w_prox[k];
    end
  end

  // Free-running blink counter; phase flips on each wrap
  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      r_cont <= '0;
      r_fase <= 1'b0;
    end else if (r_cont == c_CNT_MAX) begin
      r_cont <= '0;
      r_fase <= ~r_fase;
    end else begin
      r_cont <= r_cont + c_CNT_UM;
    end
  end

  // Lamps and horn, registered one cycle after the channel state
  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      r_lamp   <= '0;
      r_sonoro <= 1'b0;
    end else begin
      for (int k = 0; k < N_FONTES; k++) begin
        case (r_estado[k])
          ALARME, RETORNO: r_lamp[k] <= r_fase;
          RECONHECIDO:     r_lamp[k] <= 1'b1;
          default:         r_lamp[k] <= 1'b0;
        endcase
      end
      r_sonoro <= w_req & (r_timer == '0);
    end
  end

  // Silence timer; a new alarm always cancels silence, even a same-cycle press
  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      r_timer <= '0;
    end else if (|w_entra) begin
      r_timer <= '0;
    end else if (w_sil && w_req) begin
      r_timer <= c_TEMPO;
    end else if (r_timer != '0) begin
      r_timer <= r_timer - c_TIM_UM;
    end
  end

  // First-out capture, cleared only by a rearm with the whole panel quiet
  always_ff @(posedge CLOCK or negedge reset) begin
    if (!reset) begin
      r_pf <= '0;
    end else if ((r_pf == '0) && (|w_entra)) begin
      r_pf <= w_pf_novo;
    end else if (w_rea && w_todos_normal) begin
      r_pf <= '0;
    end
  end

  assign alarmeSonoro  = r_sonoro;
  assign lampadas      = r_lamp;
  assign primeiraFalha = r_pf;
  assign silenciado    = (r_timer != '0);

endmodule

`default_nettype wire

// File: tb/tb_anunciador_alarme.sv
// ============================================================================
// Module   : tb_anunciador_alarme
// Brief    : Self-checking bench for anunciador_alarme. A behavioural model
//            pushes the expected outputs into a queue at every clock edge;
//            they are popped and compared against the DUT shortly after.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_anunciador_alarme;

  localparam int N = 4;
  localparam int P = 8;
  localparam int T = 64;

  logic         CLOCK = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] ent   = '0;
  logic         rec   = 1'b0;
  logic         sil   = 1'b0;
  logic         rea   = 1'b0;

  logic         alarmeSonoro;
  logic [N-1:0] lampadas;
  logic [N-1:0] primeiraFalha;
  logic         silenciado;

  anunciador_alarme #(
    .N_FONTES       (N),
    .PERIODO_PISCA  (P),
    .TEMPO_SILENCIO (T)
  ) dut (
    .CLOCK           (CLOCK),
    .reset           (reset),
    .alarmeEntrada   (ent),
    .botaoReconhecer (rec),
    .botaoSilenciar  (sil),
    .botaoRearmar    (rea),
    .alarmeSonoro    (alarmeSonoro),
    .lampadas        (lampadas),
    .primeiraFalha   (primeiraFalha),
    .silenciado      (silenciado)
  );

  always #5 CLOCK = ~CLOCK;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic         horn;
    logic [N-1:0] lamp;
    logic [N-1:0] pf;
    logic         sil;
  } saida_t;

  saida_t fila[$];

  // Reference model state (0=NORMAL 1=ALARME 2=RECONHECIDO 3=RETORNO)
  int           m_st [N];
  int           m_cnt;
  bit           m_fase;
  int           m_tim;
  logic [N-1:0] m_pf;
  logic [N-1:0] m_lamp;
  bit           m_horn;
  bit           p_rec, p_sil, p_rea, m_armado;

  task automatic chk(input string tag, input logic [31:0] obt, input logic [31:0] esp);
    n_vec++;
    if (obt !== esp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obt, esp, $time);
    end
  endtask

  task automatic modelo_reset();
    for (int k = 0; k < N; k++) m_st[k] = 0;
    m_cnt = 0; m_fase = 0; m_tim = 0; m_pf = '0; m_lamp = '0; m_horn = 0;
    p_rec = 0; p_sil = 0; p_rea = 0; m_armado = 0;
    fila.delete();
  endtask

  // Advance the model by one clock edge using the inputs that the DUT sampled
  task automatic modelo_passo();
    bit e_rec, e_sil, e_rea, req, todos;
    int ns [N];
    logic [N-1:0] entra;
    saida_t s;
    e_rec = m_armado && rec && !p_rec;
    e_sil = m_armado && sil && !p_sil;
    e_rea = m_armado && rea && !p_rea;
    p_rec = rec; p_sil = sil; p_rea = rea; m_armado = 1;

    req = 0; todos = 1; entra = '0;
    for (int k = 0; k < N; k++) begin
      if (m_st[k] == 1 || m_st[k] == 3) req = 1;
      if (m_st[k] != 0) todos = 0;
      if (m_st[k] == 2)      m_lamp[k] = 1'b1;
      else if (m_st[k] == 0) m_lamp[k] = 1'b0;
      else                   m_lamp[k] = m_fase;
    end
    m_horn = req && (m_tim == 0);

    for (int k = 0; k < N; k++) begin
      ns[k] = m_st[k];
      if (m_st[k] == 0) begin
        if (ent[k]) begin ns[k] = 1; entra[k] = 1'b1; end
      end else if (m_st[k] == 1) begin
        if (e_rec && ent[k]) ns[k] = 2;
        else if (e_rec)      ns[k] = 0;
        else if (!ent[k])    ns[k] = 3;
      end else if (m_st[k] == 2) begin
        if (!ent[k]) ns[k] = 0;
      end else begin
        if (ent[k])     begin ns[k] = 1; entra[k] = 1'b1; end
        else if (e_rec) ns[k] = 0;
      end
    end

    if (entra != '0)        m_tim = 0;
    else if (e_sil && req)  m_tim = T;
    else if (m_tim > 0)     m_tim = m_tim - 1;

    if (m_pf == '0 && entra != '0) begin
      for (int k = 0; k < N; k++) begin
        if (entra[k]) begin m_pf[k] = 1'b1; break; end
      end
    end else if (e_rea && todos) begin
      m_pf = '0;
    end

    if (m_cnt == P - 1) begin m_cnt = 0; m_fase = !m_fase; end
    else m_cnt = m_cnt + 1;

    for (int k = 0; k < N; k++) m_st[k] = ns[k];

    s.horn = m_horn; s.lamp = m_lamp; s.pf = m_pf; s.sil = (m_tim != 0);
    fila.push_back(s);
  endtask

  task automatic passo();
    saida_t e;
    @(posedge CLOCK);
    modelo_passo();
    #1;
    e = fila.pop_front();
    chk("horn",   32'(alarmeSonoro),  32'(e.horn));
    chk("lamps",  32'(lampadas),      32'(e.lamp));
    chk("first",  32'(primeiraFalha), 32'(e.pf));
    chk("silenc", 32'(silenciado),    32'(e.sil));
  endtask

  task automatic rodar(input int n);
    for (int i = 0; i < n; i++) passo();
  endtask

  // 0=ack 1=silence 2=rearm; held three cycles to show it acts only once
  task automatic aperta(input int qual);
    if (qual == 0) rec = 1; else if (qual == 1) sil = 1; else rea = 1;
    rodar(3);
    rec = 0; sil = 0; rea = 0;
  endtask

  task automatic checa_zero(input string tag);
    chk({tag, "_horn"},  32'(alarmeSonoro),  32'h0);
    chk({tag, "_lamps"}, 32'(lampadas),      32'h0);
    chk({tag, "_first"}, 32'(primeiraFalha), 32'h0);
    chk({tag, "_silen"}, 32'(silenciado),    32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // Power-on reset
    #1 reset = 0;
    #1 checa_zero("rst");
    modelo_reset();
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK) reset = 1;
    rodar(3);

    // Ventilation alarm: ALARME, horn two edges later, blinking, first-out
    ent = 4'b0001;
    passo();
    chk("horn_1c", 32'(alarmeSonoro), 32'h0);
    passo();
    chk("horn_2c", 32'(alarmeSonoro), 32'h1);
    chk("pf_vent", 32'(primeiraFalha), 32'h1);
    rodar(30);

    // Acknowledge: lamp steady, horn off; drop input -> lamp off
    aperta(0);
    rodar(4);
    chk("ack_lamp", 32'(lampadas), 32'h1);
    chk("ack_horn", 32'(alarmeSonoro), 32'h0);
    ent = 4'b0000;
    rodar(3);
    chk("rtn_lamp", 32'(lampadas), 32'h0);

    // Rearm with panel quiet
    aperta(2);
    chk("rearm1", 32'(primeiraFalha), 32'h0);

    // Control-room alarm returns without ack, then ack clears it
    ent = 4'b0100;
    rodar(5);
    ent = 4'b0000;
    rodar(20);
    chk("ret_horn", 32'(alarmeSonoro), 32'h1);
    aperta(0);
    rodar(2);
    chk("ret_lamp", 32'(lampadas), 32'h0);
    chk("ret_hoff", 32'(alarmeSonoro), 32'h0);
    aperta(2);

    // Temperature alarm, silence, reactor raised mid-silence
    ent = 4'b0010;
    rodar(4);
    aperta(1);
    chk("sil_on", 32'(silenciado), 32'h1);
    chk("sil_hrn", 32'(alarmeSonoro), 32'h0);
    rodar(7);
    ent = 4'b1010;
    passo();
    chk("sil_clr", 32'(silenciado), 32'h0);
    passo();
    chk("sil_hrn2", 32'(alarmeSonoro), 32'h1);
    chk("sil_pf", 32'(primeiraFalha), 32'h2);
    ent = 4'b0000;
    rodar(2);
    aperta(0);
    rodar(2);
    aperta(2);

    // Simultaneous entries: lowest index wins; full silence expiry
    ent = 4'b1010;
    rodar(3);
    chk("sim_pf", 32'(primeiraFalha), 32'h2);
    aperta(2);
    chk("sim_rearm_ign", 32'(primeiraFalha), 32'h2);
    aperta(1);
    rodar(70);
    chk("sil_exp", 32'(silenciado), 32'h0);
    chk("sil_exp_h", 32'(alarmeSonoro), 32'h1);
    // Silence press and new alarm in the same cycle: new alarm wins
    aperta(1);
    rodar(4);
    ent = 4'b1011;
    sil = 1;
    passo();
    sil = 0;
    chk("sil_race", 32'(silenciado), 32'h0);
    rodar(2);
    aperta(0);
    ent = 4'b0000;
    rodar(3);
    aperta(2);
    chk("rearm2", 32'(primeiraFalha), 32'h0);

    // Reset mid-ALARME with the input held; ack held across release
    ent = 4'b0001;
    rodar(5);
    #2 reset = 0;
    #1 checa_zero("mid");
    modelo_reset();
    rec = 1;
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK) reset = 1;
    passo();
    passo();
    chk("post_horn", 32'(alarmeSonoro), 32'h1);
    rodar(3);
    rec = 0;
    rodar(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
